// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between a byte-addressed request port and a
// 64-bit doubleword memory (mem_model) with masked writes and one-cycle
// read latency. Accesses that cross a doubleword boundary are split into
// two memory beats; load data is realigned and sign/zero-extended.
//
// Ports
//   clk, rst          single clock, asynchronous active-high reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_we            1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 double
//   req_unsigned      load zero-extend when 1, sign-extend when 0
//   req_addr          byte address (ADDR_WID+3 bits)
//   req_wdata         store data, right-justified
//   rsp_valid         one-cycle completion pulse
//   rsp_rdata         extended load data, held until the next load response
//   mem_addr/wr_en/wdata/wmask, mem_rdata   doubleword memory port
module dmem_lsu #(
  parameter int ADDR_WID = 29
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WID+2:0]   req_addr,
  input  logic [63:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [63:0]           rsp_rdata,
  output logic [ADDR_WID-1:0]   mem_addr,
  output logic                  mem_wr_en,
  output logic [63:0]           mem_wdata,
  output logic [7:0]            mem_wmask,
  input  logic [63:0]           mem_rdata
);

  typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, CAPT, RESP} state_t;

  state_t                state_q;
  logic [ADDR_WID-1:0]   mem_addr_q;
  logic                  mem_wr_en_q;
  logic [63:0]           mem_wdata_q;
  logic [7:0]            mem_wmask_q;
  logic                  rsp_valid_q;
  logic [63:0]           rsp_rdata_q;

  // Request fields latched on acceptance
  logic                  we_q;
  logic                  uns_q;
  logic                  split_q;
  logic [1:0]            size_q;
  logic [2:0]            off_q;
  logic [63:0]           wdata_q;
  logic [63:0]           lo_q;

  // Byte lane placement shared by both beats
  logic [1:0]            lane_size;
  logic [2:0]            lane_off;
  logic [63:0]           lane_src;
  logic [15:0]           lane_mask;
  logic [127:0]          lane_data;

  function automatic logic [3:0] nbytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

  function automatic logic is_split(input logic [1:0] size, input logic [2:0] off);
    return ({1'b0, off} + nbytes(size)) > 4'd8;
  endfunction

  // 16-bit mask spanning two doublewords: low byte is beat 0, high byte beat 1
  function automatic logic [15:0] byte_mask(input logic [1:0] size, input logic [2:0] off);
    logic [15:0] m;
    m = (16'd1 << nbytes(size)) - 16'd1;
    return m << off;
  endfunction

  // Store data placed across two doublewords: low half beat 0, high half beat 1
  function automatic logic [127:0] place_data(input logic [63:0] wd, input logic [2:0] off);
    return {64'd0, wd} << {off, 3'b000};
  endfunction

  // Realign the {hi,lo} pair to byte 0, keep n bytes, then extend
  function automatic logic [63:0] load_ext(input logic [127:0] raw, input logic [2:0] off,
                                           input logic [1:0] size, input logic uns);
    logic [63:0] sh;
    logic [63:0] res;
    sh = 64'(raw >> {off, 3'b000});
    case (size)
      2'b00:   res = uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      2'b01:   res = uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'b10:   res = uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  // While idle the lanes follow the live request so BEAT0 values can be
  // registered on the accept edge; afterwards they follow the latched copy.
  always_comb begin
    lane_size = size_q;
    lane_off  = off_q;
    lane_src  = wdata_q;
    if (state_q == IDLE) begin
      lane_size = req_size;
      lane_off  = req_addr[2:0];
      lane_src  = req_wdata;
    end
    lane_mask = byte_mask(lane_size, lane_off);
    lane_data = place_data(lane_src, lane_off);
  end

  // Control FSM with registered memory-port and response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wr_en_q <= 1'b0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            mem_addr_q  <= req_addr[ADDR_WID+2:3];
            mem_wmask_q <= lane_mask[7:0];
            mem_wdata_q <= lane_data[63:0];
            mem_wr_en_q <= req_we;
            state_q     <= BEAT0;
          end
        end
        BEAT0: begin
          if (split_q) begin
            mem_addr_q  <= mem_addr_q + ADDR_WID'(1);
            mem_wmask_q <= lane_mask[15:8];
            mem_wdata_q <= lane_data[127:64];
            mem_wr_en_q <= we_q;
            state_q     <= BEAT1;
          end else begin
            mem_wr_en_q <= 1'b0;
            if (we_q) begin
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              state_q     <= CAPT;
            end
          end
        end
        BEAT1: begin
          mem_wr_en_q <= 1'b0;
          if (we_q) begin
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            state_q     <= CAPT;
          end
        end
        CAPT: begin
          // mem_rdata here belongs to the last beat: high dw if split, else low
          rsp_rdata_q <= load_ext(split_q ? {mem_rdata, lo_q} : {64'd0, mem_rdata},
                                  off_q, size_q, uns_q);
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Datapath captures that need no reset
  always_ff @(posedge clk) begin
    if (state_q == IDLE && req_valid) begin
      we_q    <= req_we;
      uns_q   <= req_unsigned;
      size_q  <= req_size;
      off_q   <= req_addr[2:0];
      wdata_q <= req_wdata;
      split_q <= is_split(req_size, req_addr[2:0]);
    end
    // Low doubleword of a split load arrives during BEAT1
    if (state_q == BEAT1) begin
      lo_q <= mem_rdata;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;
  localparam int AW = 4;
  localparam int NB = 8 << AW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_we = 1'b0;
  logic [1:0]      req_size = 2'b00;
  logic            req_unsigned = 1'b0;
  logic [AW+2:0]   req_addr = '0;
  logic [63:0]     req_wdata = '0;
  logic            rsp_valid;
  logic [63:0]     rsp_rdata;
  logic [AW-1:0]   mem_addr;
  logic            mem_wr_en;
  logic [63:0]     mem_wdata;
  logic [7:0]      mem_wmask;
  logic [63:0]     mem_rdata;

  always #5 clk = ~clk;

  dmem_lsu #(.ADDR_WID(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  // Attached memory: masked write on the edge, read data one cycle later
  logic [63:0] bmem [2**AW] = '{default: 64'd0};
  logic [63:0] rd_q = 64'd0;
  logic [63:0] wword;
  always @(posedge clk) begin
    if (mem_wr_en) begin
      wword = bmem[mem_addr];
      for (int b = 0; b < 8; b++)
        if (mem_wmask[b]) wword[8*b +: 8] = mem_wdata[8*b +: 8];
      bmem[mem_addr] <= wword;
    end
    rd_q <= bmem[mem_addr];
  end
  assign mem_rdata = rd_q;

  // Reference model: flat byte memory plus a queue of expected responses
  typedef struct {
    int          due;
    bit          load;
    logic [63:0] data;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  refm [NB];
  logic [7:0]  saved [NB];
  int          tests = 0;
  int          fails = 0;
  int          edge_cnt = 0;
  int          acc_cnt = 0;
  int          rsp_cnt = 0;
  logic [63:0] hold = 64'd0;

  function automatic int nby(input logic [1:0] s);
    return 1 << s;
  endfunction

  function automatic logic [63:0] model_load(input logic [AW+2:0] a, input logic [1:0] s,
                                             input logic u);
    logic [63:0] v;
    int n;
    v = 64'd0;
    n = nby(s);
    for (int i = 0; i < n; i++) v[8*i +: 8] = refm[(int'(a) + i) % NB];
    if (!u && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mem_cmp(input string name);
    int bad;
    int first;
    bad = 0;
    first = -1;
    for (int i = 0; i < NB; i++)
      if (bmem[i >> 3][(i & 7)*8 +: 8] !== refm[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s: %0d bytes differ, first at byte %0d got %h expected %h", name, bad,
               first, bmem[first >> 3][(first & 7)*8 +: 8], refm[first]);
    end
  endtask

  // One clock: record what the coming edge accepts, then check outputs at negedge
  task automatic tick();
    bit            acc;
    logic          we, uns;
    logic [1:0]    sz;
    logic [AW+2:0] a;
    logic [63:0]   wd;
    bit            split, exp_v;
    int            n, lat;
    exp_t          e;
    acc = req_valid && req_ready && !rst;
    we = req_we; uns = req_unsigned; sz = req_size; a = req_addr; wd = req_wdata;
    @(negedge clk);
    edge_cnt++;
    if (acc && !rst) begin
      acc_cnt++;
      n = nby(sz);
      split = (int'(a[2:0]) + n) > 8;
      lat = we ? (split ? 3 : 2) : (split ? 4 : 3);
      e.due = edge_cnt + lat - 1;
      e.load = !we;
      e.data = 64'd0;
      if (we) begin
        for (int i = 0; i < n; i++) refm[(int'(a) + i) % NB] = wd[8*i +: 8];
      end else begin
        e.data = model_load(a, sz, uns);
      end
      q.push_back(e);
    end
    if (rst) begin
      check64("reset_rsp", {62'd0, rsp_valid, mem_wr_en}, 64'd0);
      check64("reset_rdata", rsp_rdata, 64'd0);
      check64("reset_memport", mem_wdata | 64'(mem_wmask) | 64'(mem_addr), 64'd0);
      q.delete();
      hold = 64'd0;
    end else begin
      exp_v = (q.size() > 0) && (q[0].due == edge_cnt);
      check64("rsp_valid", 64'(rsp_valid), 64'(exp_v));
      if (exp_v) begin
        e = q.pop_front();
        rsp_cnt++;
        if (e.load) hold = e.data;
        else mem_cmp("mem_after_store");
      end else if (q.size() > 0 && q[0].due < edge_cnt) begin
        void'(q.pop_front());
      end
      check64("rsp_rdata", rsp_rdata, hold);
      check64("req_ready", 64'(req_ready), 64'(q.size() == 0 && !exp_v));
      if (q.size() == 0 && !exp_v) check64("idle_wr_en", 64'(mem_wr_en), 64'd0);
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [AW+2:0] a, input logic [63:0] wd);
    int g;
    g = 0;
    while (!req_ready && g < 50) begin
      tick();
      g++;
    end
    check64("ready_wait", 64'(req_ready), 64'd1);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int start, output int lat);
    lat = start;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  int lat;

  initial begin
    for (int i = 0; i < NB; i++) refm[i] = 8'h00;
    repeat (3) tick();
    #2 rst = 1'b0;
    tick();
    check64("ready_after_reset", 64'(req_ready), 64'd1);

    // Aligned double store
    issue(1'b1, 2'b11, 1'b0, 7'h08, 64'h1122334455667788);
    check64("st_d_addr", 64'(mem_addr), 64'd1);
    check64("st_d_mask", 64'(mem_wmask), 64'hFF);
    check64("st_d_wdata", mem_wdata, 64'h1122334455667788);
    check64("st_d_wr_en", 64'(mem_wr_en), 64'd1);
    wait_rsp(1, lat);
    check64("st_d_latency", 64'(lat), 64'd2);

    // Byte loads from dw2
    issue(1'b1, 2'b11, 1'b0, 7'h10, 64'hAABBCCDDEEFF0011);
    wait_rsp(1, lat);
    issue(1'b0, 2'b00, 1'b0, 7'h17, 64'd0);
    check64("ld_b_wr_en", 64'(mem_wr_en), 64'd0);
    wait_rsp(1, lat);
    check64("ld_b_latency", 64'(lat), 64'd3);
    check64("ld_b_signed", rsp_rdata, 64'hFFFFFFFFFFFFFFAA);
    issue(1'b0, 2'b00, 1'b1, 7'h17, 64'd0);
    wait_rsp(1, lat);
    check64("ld_b_unsigned", rsp_rdata, 64'h00000000000000AA);

    // Aligned word store in the upper half
    issue(1'b1, 2'b10, 1'b0, 7'h1C, 64'h66666666);
    check64("st_w_addr", 64'(mem_addr), 64'd3);
    check64("st_w_mask", 64'(mem_wmask), 64'hF0);
    check64("st_w_wdata", mem_wdata, 64'h6666666600000000);
    wait_rsp(1, lat);

    // Split word store and load back
    issue(1'b1, 2'b10, 1'b0, 7'h0E, 64'hDEADBEEF);
    check64("sp_b0_addr", 64'(mem_addr), 64'd1);
    check64("sp_b0_mask", 64'(mem_wmask), 64'hC0);
    check64("sp_b0_wdata", mem_wdata, 64'hBEEF000000000000);
    tick();
    check64("sp_b1_addr", 64'(mem_addr), 64'd2);
    check64("sp_b1_mask", 64'(mem_wmask), 64'h03);
    check64("sp_b1_wdata", mem_wdata, 64'h000000000000DEAD);
    wait_rsp(2, lat);
    check64("sp_st_latency", 64'(lat), 64'd3);
    issue(1'b0, 2'b10, 1'b1, 7'h0E, 64'd0);
    wait_rsp(1, lat);
    check64("sp_ld_latency", 64'(lat), 64'd4);
    check64("sp_ld_data", rsp_rdata, 64'h00000000DEADBEEF);

    // Split double that wraps from the last doubleword to address 0
    issue(1'b1, 2'b11, 1'b0, 7'h7C, 64'h0102030405060708);
    tick();
    check64("wrap_b1_addr", 64'(mem_addr), 64'd0);
    wait_rsp(2, lat);
    issue(1'b0, 2'b11, 1'b0, 7'h7C, 64'd0);
    wait_rsp(1, lat);
    check64("wrap_ld_data", rsp_rdata, 64'h0102030405060708);

    // Reset during BEAT1 of a split store: only beat 0 lands
    saved = refm;
    issue(1'b1, 2'b10, 1'b0, 7'h0E, 64'h12345678);
    tick();
    check64("abort_b1_wr_en", 64'(mem_wr_en), 64'd1);
    #2 rst = 1'b1;
    #1;
    check64("abort_wr_en_now", 64'(mem_wr_en), 64'd0);
    check64("abort_rsp_now", 64'(rsp_valid), 64'd0);
    refm[16] = saved[16];
    refm[17] = saved[17];
    tick();
    tick();
    #2 rst = 1'b0;
    tick();
    check64("abort_ready", 64'(req_ready), 64'd1);
    check64("abort_dw2", bmem[2], 64'hAABBCCDDEEFFDEAD);
    mem_cmp("abort_mem");
    repeat (4) tick();

    // Random traffic with req_valid held high and fields changing every cycle
    acc_cnt = 0;
    rsp_cnt = 0;
    req_valid = 1'b1;
    for (int k = 0; k < 600; k++) begin
      req_we       = 1'($urandom_range(0, 1));
      req_size     = 2'($urandom_range(0, 3));
      req_unsigned = 1'($urandom_range(0, 1));
      req_addr     = (AW+3)'($urandom_range(0, NB - 1));
      req_wdata    = {$urandom, $urandom};
      tick();
    end
    req_valid = 1'b0;
    repeat (8) tick();
    check64("queue_drained", 64'(q.size()), 64'd0);
    check64("one_rsp_per_accept", 64'(rsp_cnt), 64'(acc_cnt));
    mem_cmp("final_mem");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
